// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts in d on enabled edges and pulses match (one clock
// after sampling) when the last PATTERN_W bits equal PATTERN. It also keeps a
// saturating match counter.
module serial_pattern_detector #(
    parameter int                   PATTERN_W = 4,
    parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
    parameter bit                   OVERLAP   = 1'b1,
    parameter int                   COUNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 d,
    input  logic                 enable,
    output logic                 match,
    output logic [COUNT_W-1:0]   match_count,
    output logic                 count_sat,
    output logic [PATTERN_W-1:0] history
);
    localparam int                 FILL_W    = $clog2(PATTERN_W + 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PATTERN_W);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [FILL_W-1:0]    fill;
    logic [FILL_W-1:0]    fill_next;
    logic [PATTERN_W-1:0] history_next;
    logic [COUNT_W-1:0]   count_next;
    logic                 hit;

    // The fill gate stops a freshly cleared all-zero history from matching an all-zero pattern.
    always_comb begin
        history_next = {history[PATTERN_W-2:0], d};
        fill_next    = (fill == FILL_FULL) ? fill : fill + 1'b1;
        hit          = (fill_next == FILL_FULL) && (history_next == PATTERN);
        count_next   = (hit && (match_count != COUNT_MAX)) ? match_count + 1'b1 : match_count;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            history     <= '0;
            fill        <= '0;
            match       <= 1'b0;
            match_count <= '0;
            count_sat   <= 1'b0;
        end else if (enable) begin
            history     <= history_next;
            match       <= hit;
            fill        <= (hit && !OVERLAP) ? '0 : fill_next;
            match_count <= count_next;
            count_sat   <= (count_next == COUNT_MAX);
        end else begin
            match <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: four parameter variants share one input stream.
// A stream-level model predicts every output, and directed scenarios pin fixed values.
module tb_serial_pattern_detector;
    logic clock = 1'b0;
    logic clear = 1'b1;
    logic d = 1'b0;
    logic enable = 1'b0;

    logic       m [4];
    logic       s [4];
    logic [3:0] h [4];
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    always #5 clock = ~clock;

    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .COUNT_W(8)) u0 (
        .clock(clock), .clear(clear), .d(d), .enable(enable),
        .match(m[0]), .match_count(cnt0), .count_sat(s[0]), .history(h[0]));
    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(8)) u1 (
        .clock(clock), .clear(clear), .d(d), .enable(enable),
        .match(m[1]), .match_count(cnt1), .count_sat(s[1]), .history(h[1]));
    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b0000), .OVERLAP(1'b1), .COUNT_W(8)) u2 (
        .clock(clock), .clear(clear), .d(d), .enable(enable),
        .match(m[2]), .match_count(cnt2), .count_sat(s[2]), .history(h[2]));
    serial_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .COUNT_W(2)) u3 (
        .clock(clock), .clear(clear), .d(d), .enable(enable),
        .match(m[3]), .match_count(cnt3), .count_sat(s[3]), .history(h[3]));

    int n_checks = 0;
    int n_fail = 0;
    bit check_on = 1'b0;

    // Model: the bit stream sampled since the last clear, plus per-variant bookkeeping.
    localparam logic [3:0] PAT [4] = '{4'b1011, 4'b1011, 4'b0000, 4'b1011};
    localparam bit         OVL [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    localparam int         CMAX[4] = '{255, 255, 255, 3};
    bit stream[$];
    int last_end [4];
    int mcount [4];
    bit msat [4];
    bit mmatch [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] last4();
        logic [3:0] v = '0;
        int n = stream.size();
        for (int i = 0; i < 4; i++)
            v = {v[2:0], (n - 4 + i >= 0) ? stream[n-4+i] : 1'b0};
        return v;
    endfunction

    function automatic int exp_fill(input int k);
        int f = stream.size() - last_end[k];
        return (f > 4) ? 4 : f;
    endfunction

    task automatic model_edge(input bit c, input bit e, input bit b);
        if (c) begin
            stream.delete();
            for (int k = 0; k < 4; k++) begin
                last_end[k] = 0; mcount[k] = 0; msat[k] = 0; mmatch[k] = 0;
            end
        end else if (e) begin
            stream.push_back(b);
            for (int k = 0; k < 4; k++) begin
                bit hit = (stream.size() - last_end[k] >= 4) && (last4() == PAT[k]);
                mmatch[k] = hit;
                if (hit) begin
                    if (!OVL[k]) last_end[k] = stream.size();
                    if (mcount[k] < CMAX[k]) mcount[k]++;
                end
                msat[k] = (mcount[k] == CMAX[k]);
            end
        end else begin
            for (int k = 0; k < 4; k++) mmatch[k] = 0;
        end
    endtask

    task automatic step(input bit c, input bit e, input bit b);
        clear = c; enable = e; d = b;
        @(posedge clock);
        model_edge(c, e, b);
        @(negedge clock);
    endtask

    function automatic logic [31:0] act_fill(input int k);
        case (k)
            0: return 32'(u0.fill);
            1: return 32'(u1.fill);
            2: return 32'(u2.fill);
            default: return 32'(u3.fill);
        endcase
    endfunction

    function automatic logic [31:0] act_cnt(input int k);
        case (k)
            0: return 32'(cnt0);
            1: return 32'(cnt1);
            2: return 32'(cnt2);
            default: return 32'(cnt3);
        endcase
    endfunction

    always @(negedge clock) begin
        if (check_on) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("model_match[%0d]", k), 32'(m[k]), 32'(mmatch[k]));
                chk($sformatf("model_count[%0d]", k), act_cnt(k), 32'(mcount[k]));
                chk($sformatf("model_sat[%0d]", k), 32'(s[k]), 32'(msat[k]));
                chk($sformatf("model_history[%0d]", k), 32'(h[k]), 32'(last4()));
                chk($sformatf("model_fill[%0d]", k), act_fill(k), 32'(exp_fill(k)));
            end
        end
    end

    initial begin
        bit seq7 [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit p1011 [4] = '{1, 0, 1, 1};

        // Overlap vs non-overlap on 1011011
        step(1, 0, 0);
        check_on = 1'b1;
        chk("reset_match", 32'(m[0]), 0);
        chk("reset_count", 32'(cnt0), 0);
        chk("reset_history", 32'(h[0]), 0);
        chk("reset_sat", 32'(s[0]), 0);
        step(1, 0, 0);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, seq7[i]);
            if (i == 3) begin
                chk("ov_match_4th", 32'(m[0]), 1);
                chk("nov_match_4th", 32'(m[1]), 1);
            end
        end
        chk("ov_match_7th", 32'(m[0]), 1);
        chk("nov_no_match_7th", 32'(m[1]), 0);
        chk("ov_count", 32'(cnt0), 2);
        chk("nov_count", 32'(cnt1), 1);
        chk("ov_history", 32'(h[0]), 32'h0000000b);
        chk("nov_fill", 32'(u1.fill), 3);

        // All-zero pattern must wait for a full history
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        chk("zero_no_early_match", 32'(m[2]), 0);
        step(0, 1, 0);
        chk("zero_match_4th", 32'(m[2]), 1);
        chk("zero_count_4th", 32'(cnt2), 1);
        step(0, 1, 0);
        chk("zero_match_5th", 32'(m[2]), 1);

        // Enable low holds history and does not stretch or create matches
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            chk("hold_no_match", 32'(m[0]), 0);
        end
        chk("hold_history_low", 32'(h[0][1:0]), 2);
        step(0, 1, 1);
        step(0, 1, 1);
        chk("hold_resume_match", 32'(m[0]), 1);

        // Two-bit counter saturation
        step(1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) step(0, 1, p1011[i]);
            chk("sat_pulse", 32'(m[3]), 1);
            chk("sat_count", 32'(cnt3), (r < 3) ? r + 1 : 3);
            chk("sat_flag", 32'(s[3]), (r >= 2) ? 1 : 0);
        end

        // Clear in the middle of a pattern discards it and ignores d
        step(1, 0, 0);
        step(0, 1, 1);
        step(0, 1, 0);
        step(0, 1, 1);
        step(1, 1, 1);
        step(0, 1, 1);
        chk("clr_no_match", 32'(m[0]), 0);
        chk("clr_count", 32'(cnt0), 0);
        chk("clr_history", 32'(h[0]), 1);
        chk("clr_fill", 32'(u0.fill), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));

        check_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
